// File: rtl/gctr_job_sequencer.sv
// gctr_job_sequencer
//   Sequences one GCM job through the GCTR block engine: hash-key derivation
//   (H), N counter-mode data blocks, then the E(K,Y0) tag mask. Results leave
//   on a single tagged output stream; only one engine command is in flight.
//
// Ports
//   iClk / iRst          clock, asynchronous active-high reset
//   iStart, iIV, iKey,   job start pulse and job fields (latched when idle)
//   iKeylen, iNumBlocks
//   oBusy                job in progress
//   iBlock*, oBlock_ready  input data block handshake
//   oOut*, iOut_ready    tagged output stream (00=H, 01=data, 10=E(K,Y0))
//   oDone, oError        end-of-job pulse, sticky watchdog abort flag
//   oG_*                 engine command fields
//   iG_result*           engine result strobe
//
// Configuration
//   GCTR_SEQ_TIMEOUT_EN  when defined, a watchdog aborts a *_WAIT state after
//                        TIMEOUT_CYCLES cycles without an engine result.
module gctr_job_sequencer #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [95:0]      iIV,
    input  logic [255:0]     iKey,
    input  logic             iKeylen,
    input  logic [CNT_W-1:0] iNumBlocks,
    output logic             oBusy,
    input  logic [127:0]     iBlock,
    input  logic             iBlock_valid,
    output logic             oBlock_ready,
    output logic [127:0]     oOut,
    output logic [1:0]       oOut_type,
    output logic             oOut_valid,
    input  logic             iOut_ready,
    output logic             oDone,
    output logic             oError,
    output logic             oG_init,
    output logic [95:0]      oG_iv,
    output logic             oG_iv_valid,
    output logic [255:0]     oG_key,
    output logic             oG_key_valid,
    output logic             oG_keylen,
    output logic             oG_y0,
    output logic             oG_hashkey,
    output logic [127:0]     oG_block,
    output logic             oG_block_valid,
    input  logic [127:0]     iG_result,
    input  logic             iG_result_valid
);

    typedef enum logic [3:0] {
        IDLE, HK_ISSUE, HK_WAIT, FETCH, BLK_ISSUE, BLK_WAIT,
        Y0_ISSUE, Y0_WAIT, OUT, FIN
    } state_t;

    localparam logic [1:0] T_H    = 2'b00;
    localparam logic [1:0] T_DATA = 2'b01;
    localparam logic [1:0] T_EK0  = 2'b10;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t             state_q, state_d;
    logic [95:0]        iv_q, iv_d;
    logic [255:0]       key_q, key_d;
    logic               keylen_q, keylen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_dec;
    logic [127:0]       blk_q, blk_d;
    logic [127:0]       out_q, out_d;
    logic [1:0]         type_q, type_d;
    logic               err_q, err_d;
    logic               timeout;
    logic               in_hk, in_blk, in_y0, in_issue;

    assign in_hk    = (state_q == HK_ISSUE)  || (state_q == HK_WAIT);
    assign in_blk   = (state_q == BLK_ISSUE) || (state_q == BLK_WAIT);
    assign in_y0    = (state_q == Y0_ISSUE)  || (state_q == Y0_WAIT);
    assign in_issue = (state_q == HK_ISSUE) || (state_q == BLK_ISSUE) ||
                      (state_q == Y0_ISSUE);

    // Saturating decrement: the remaining count never wraps below zero.
    assign cnt_dec = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;

`ifdef GCTR_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            in_wait;

    assign in_wait = (state_q == HK_WAIT) || (state_q == BLK_WAIT) ||
                     (state_q == Y0_WAIT);
    // wd_q counts completed wait cycles; the first wait cycle sees 0, so the
    // abort fires on the TIMEOUT_CYCLES-th cycle without a result.
    assign timeout = in_wait && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)         wd_q <= '0;
        else if (in_wait) wd_q <= wd_q + WD_W'(1);
        else              wd_q <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= IDLE;
            iv_q     <= '0;
            key_q    <= '0;
            keylen_q <= 1'b0;
            cnt_q    <= '0;
            blk_q    <= '0;
            out_q    <= '0;
            type_q   <= T_H;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            iv_q     <= iv_d;
            key_q    <= key_d;
            keylen_q <= keylen_d;
            cnt_q    <= cnt_d;
            blk_q    <= blk_d;
            out_q    <= out_d;
            type_q   <= type_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        iv_d         = iv_q;
        key_d        = key_q;
        keylen_d     = keylen_q;
        cnt_d        = cnt_q;
        blk_d        = blk_q;
        out_d        = out_q;
        type_d       = type_q;
        err_d        = err_q;
        oBlock_ready = 1'b0;
        oOut_valid   = 1'b0;
        oDone        = 1'b0;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    iv_d     = iIV;
                    key_d    = iKey;
                    keylen_d = iKeylen;
                    cnt_d    = iNumBlocks;
                    err_d    = 1'b0;
                    state_d  = HK_ISSUE;
                end
            end
            HK_ISSUE:  state_d = HK_WAIT;
            BLK_ISSUE: state_d = BLK_WAIT;
            Y0_ISSUE:  state_d = Y0_WAIT;
            HK_WAIT, BLK_WAIT, Y0_WAIT: begin
                // A result arriving on the last watchdog cycle still wins.
                if (iG_result_valid) begin
                    out_d   = iG_result;
                    type_d  = (state_q == HK_WAIT)  ? T_H :
                              (state_q == BLK_WAIT) ? T_DATA : T_EK0;
                    state_d = OUT;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end
            end
            FETCH: begin
                oBlock_ready = 1'b1;
                if (iBlock_valid) begin
                    blk_d   = iBlock;
                    state_d = BLK_ISSUE;
                end
            end
            OUT: begin
                oOut_valid = 1'b1;
                if (iOut_ready) begin
                    case (type_q)
                        T_H:     state_d = (cnt_q != '0) ? FETCH : Y0_ISSUE;
                        T_DATA: begin
                            cnt_d   = cnt_dec;
                            state_d = (cnt_dec != '0) ? FETCH : Y0_ISSUE;
                        end
                        default: state_d = FIN;
                    endcase
                end
            end
            FIN: begin
                oDone   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Engine command fields: live only from *_ISSUE through *_WAIT, zero
    // elsewhere, so a reset or abort drops them immediately.
    always_comb begin
        oG_init        = in_issue;
        oG_iv          = '0;
        oG_key         = '0;
        oG_keylen      = 1'b0;
        oG_iv_valid    = 1'b0;
        oG_key_valid   = 1'b0;
        oG_hashkey     = in_hk;
        oG_y0          = in_y0;
        oG_block       = '0;
        oG_block_valid = in_blk;
        if (in_hk || in_blk || in_y0) begin
            oG_iv        = iv_q;
            oG_key       = key_q;
            oG_keylen    = keylen_q;
            oG_iv_valid  = 1'b1;
            oG_key_valid = 1'b1;
        end
        if (in_blk) oG_block = blk_q;
    end

    assign oBusy     = (state_q != IDLE);
    assign oOut      = out_q;
    assign oOut_type = type_q;
    assign oError    = err_q;

endmodule

// File: tb/tb_gctr_job_sequencer.sv
// Directed bench for gctr_job_sequencer. A behavioural engine answers each
// command after a fixed latency using the known test-vector keystream
// (P xor C), so expected stream words are the published vectors.
module tb_gctr_job_sequencer;

    localparam int CNT_W   = 16;
    localparam int TO      = 40;
    localparam int ENG_LAT = 2;

    localparam logic [255:0] KEY = 256'hE3C08A8F06C6E3AD95A70557B23F75483CE33021A9C72B7025666204C69C0B72;
    localparam logic [95:0]  IV  = 96'h12153524C0895E81B2C28465;
    localparam logic [127:0] HV  = 128'h286D73994EA0BA3CFD1F52BF06A8ACF2;
    localparam logic [127:0] EK0 = 128'h714D54FDCFCEE37D5729CDDAB383A016;

    logic             clk = 1'b0;
    logic             rst;
    logic             iStart, iKeylen, iBlock_valid, iOut_ready, iG_result_valid;
    logic [95:0]      iIV;
    logic [255:0]     iKey;
    logic [CNT_W-1:0] iNumBlocks;
    logic [127:0]     iBlock, iG_result;
    logic             oBusy, oBlock_ready, oOut_valid, oDone, oError;
    logic [127:0]     oOut, oG_block;
    logic [1:0]       oOut_type;
    logic             oG_init, oG_iv_valid, oG_key_valid, oG_keylen, oG_y0, oG_hashkey, oG_block_valid;
    logic [95:0]      oG_iv;
    logic [255:0]     oG_key;

    always #5 clk = ~clk;

    gctr_job_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .iClk(clk), .iRst(rst), .iStart(iStart), .iIV(iIV), .iKey(iKey),
        .iKeylen(iKeylen), .iNumBlocks(iNumBlocks), .oBusy(oBusy),
        .iBlock(iBlock), .iBlock_valid(iBlock_valid), .oBlock_ready(oBlock_ready),
        .oOut(oOut), .oOut_type(oOut_type), .oOut_valid(oOut_valid),
        .iOut_ready(iOut_ready), .oDone(oDone), .oError(oError),
        .oG_init(oG_init), .oG_iv(oG_iv), .oG_iv_valid(oG_iv_valid),
        .oG_key(oG_key), .oG_key_valid(oG_key_valid), .oG_keylen(oG_keylen),
        .oG_y0(oG_y0), .oG_hashkey(oG_hashkey), .oG_block(oG_block),
        .oG_block_valid(oG_block_valid), .iG_result(iG_result),
        .iG_result_valid(iG_result_valid)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    logic [127:0] P [3];
    logic [127:0] C [3];
    logic [127:0] ks [3];
    logic [127:0] in_blk [3];

    // Job context shared with the engine model
    int           job_n = 0;
    logic [95:0]  job_iv = '0;
    logic [255:0] job_key = '0;
    bit           eng_en = 1'b1;
    bit           spur = 1'b0;
    int           eng_wait = -1;
    int           cmd_no = 0;
    int           n_init = 0;
    logic [127:0] eng_res = '0;

    // Engine model: checks each command and answers ENG_LAT cycles later.
    initial begin
        logic [2:0] kind;
        iG_result_valid = 1'b0;
        iG_result = '0;
        forever begin
            @(negedge clk);
            iG_result_valid = 1'b0;
            if (rst || !eng_en) eng_wait = -1;
            if (!oBusy) cmd_no = 0;
            if (!rst && oG_init) begin
                n_init++;
                chk("cmd_overlap", 256'(eng_wait == -1), 256'(1));
                chk("cmd_iv", 256'(oG_iv), 256'(job_iv));
                chk("cmd_key", oG_key, job_key);
                chk("cmd_keylen_valids", 256'({oG_keylen, oG_iv_valid, oG_key_valid}), 256'(3'b111));
                kind = (cmd_no == 0) ? 3'b100 : (cmd_no <= job_n) ? 3'b010 : 3'b001;
                chk("cmd_kind", 256'({oG_hashkey, oG_block_valid, oG_y0}), 256'(kind));
                if (oG_hashkey) eng_res = HV;
                else if (oG_y0) eng_res = EK0;
                else if (cmd_no >= 1 && cmd_no <= 3) begin
                    chk("cmd_block", 256'(oG_block), 256'(in_blk[cmd_no-1]));
                    eng_res = oG_block ^ ks[cmd_no-1];
                end else eng_res = '0;
                cmd_no++;
                eng_wait = ENG_LAT;
            end else if (eng_wait > 0) eng_wait--;
            if (eng_wait == 0) begin
                iG_result_valid = 1'b1;
                iG_result = eng_res;
                eng_wait = -1;
            end else if (spur) begin
                iG_result_valid = 1'b1;
                iG_result = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
            end
        end
    end

    task automatic start_job(input int n);
        @(negedge clk);
        iIV = IV; iKey = KEY; iKeylen = 1'b1; iNumBlocks = CNT_W'(n);
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    task automatic run_job(input int n, input bit dec, input bit stall, input bit rst_mid, input string nm);
        logic [127:0] expw [5];
        logic [1:0]   expt [5];
        logic [127:0] cur = '0;
        logic [1:0]   curt = '0;
        int idx = 0, bi = 0, n_done = 0, n_rdy = 0, cyc = 0, stall_left = 0, init0;
        int dly = stall ? 5 : 0;
        bit have = 0, stable = 1, fin = 0;

        job_n = n; job_iv = IV; job_key = KEY;
        for (int i = 0; i < 3; i++) in_blk[i] = dec ? C[i] : P[i];
        expw[0] = HV; expt[0] = 2'b00;
        for (int i = 0; i < n; i++) begin
            expw[i+1] = dec ? P[i] : C[i];
            expt[i+1] = 2'b01;
        end
        expw[n+1] = EK0; expt[n+1] = 2'b10;
        iOut_ready = !stall;
        init0 = n_init;
        start_job(n);
        chk({nm, "_start_lat"}, 256'(oG_init), 256'(1));

        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (oDone) begin n_done++; fin = 1; end
            if (stall && cyc == 15) begin
                iIV = ~IV; iKey = ~KEY; iKeylen = 1'b0; iNumBlocks = 7; iStart = 1'b1;
            end else iStart = 1'b0;

            if (rst_mid && oG_block_valid && !oG_init) begin
                rst = 1'b1;
                #1;
                chk({nm, "_rst_zero"}, 256'({oBusy, oG_iv_valid, oG_key_valid, oG_block_valid,
                    oG_init, oOut_valid, oDone, oBlock_ready}), 256'(0));
                chk({nm, "_rst_out"}, 256'(oOut), 256'(0));
                chk({nm, "_rst_gblock"}, 256'(oG_block), 256'(0));
                iBlock_valid = 1'b0;
                @(negedge clk);
                chk({nm, "_rst_nodone"}, 256'(oDone), 256'(0));
                @(negedge clk);
                rst = 1'b0;
                return;
            end

            if (oBlock_ready) begin
                n_rdy++;
                if (dly > 0) begin dly--; iBlock_valid = 1'b0; end
                else begin
                    iBlock_valid = 1'b1;
                    iBlock = (bi < 3) ? in_blk[bi] : '0;
                    bi++;
                    dly = stall ? 5 : 0;
                end
            end else begin
                // Offer a junk block while not ready; it must not be consumed.
                iBlock_valid = stall;
                iBlock = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
            end

            if (oOut_valid) begin
                if (!have) begin
                    have = 1; cur = oOut; curt = oOut_type; stable = 1;
                    stall_left = stall ? 10 : 0;
                    if (idx < n + 2) begin
                        chk($sformatf("%s_word%0d", nm, idx), 256'(oOut), 256'(expw[idx]));
                        chk($sformatf("%s_type%0d", nm, idx), 256'(oOut_type), 256'(expt[idx]));
                    end else chk({nm, "_extra_word"}, 256'(idx), 256'(n + 1));
                end else stable &= (oOut === cur) && (oOut_type === curt);
                if (stall_left > 0) begin
                    iOut_ready = 1'b0;
                    stall_left--;
                end else begin
                    if (stall) chk($sformatf("%s_stable%0d", nm, idx), 256'(stable), 256'(1));
                    iOut_ready = 1'b1;
                    have = 0;
                    idx++;
                end
            end
        end
        iBlock_valid = 1'b0;
        iStart = 1'b0;
        if (!fin) chk({nm, "_job_timeout"}, 256'(0), 256'(1));
        chk({nm, "_nwords"}, 256'(idx), 256'(n + 2));
        chk({nm, "_ninit"}, 256'(n_init - init0), 256'(n + 2));
        chk({nm, "_nblocks"}, 256'(bi), 256'(n));
        if (n == 0) chk({nm, "_no_ready"}, 256'(n_rdy), 256'(0));
        chk({nm, "_err"}, 256'(oError), 256'(0));
        @(negedge clk);
        chk({nm, "_idle"}, 256'({oBusy, oDone}), 256'(0));
        iOut_ready = 1'b1;
    endtask

    initial begin
        P[0] = 128'h08000F101112131415161718191A1B1C;
        P[1] = 128'h1D1E1F202122232425262728292A2B2C;
        P[2] = 128'h2D2E2F303132333435363738393A0002;
        C[0] = 128'hE2006EB42F5277022D9B19925BC419D7;
        C[1] = 128'hA592666C925FE2EF718EB4E308EFEAA7;
        C[2] = 128'hC5273B394118860A5BE2A97F56AB7836;
        for (int i = 0; i < 3; i++) ks[i] = P[i] ^ C[i];

        rst = 1'b1; iStart = 1'b0; iIV = '0; iKey = '0; iKeylen = 1'b0; iNumBlocks = '0;
        iBlock = '0; iBlock_valid = 1'b0; iOut_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 256'({oBusy, oOut_valid, oDone, oError, oBlock_ready}), 256'(0));
        chk("reset_cmd", 256'({oG_init, oG_iv_valid, oG_key_valid, oG_block_valid, oG_hashkey, oG_y0}), 256'(0));
        chk("reset_out", 256'({oOut, oOut_type}), 256'(0));
        rst = 1'b0;

        run_job(3, 1'b0, 1'b0, 1'b0, "enc");

        // Stray engine strobe while idle must not produce an output word.
        spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        chk("spur_valid", 256'({oOut_valid, oBusy}), 256'(0));
        chk("spur_out", 256'(oOut), 256'(EK0));

        run_job(3, 1'b1, 1'b0, 1'b0, "dec");
        run_job(0, 1'b0, 1'b0, 1'b0, "n0");
        run_job(3, 1'b0, 1'b1, 1'b0, "stall");
        run_job(3, 1'b0, 1'b0, 1'b1, "rstmid");
        run_job(3, 1'b0, 1'b0, 1'b0, "after_rst");

`ifdef GCTR_SEQ_TIMEOUT_EN
        begin
            int cyc = 0;
            eng_en = 1'b0;
            job_n = 1; job_iv = IV; job_key = KEY;
            start_job(1);
            cyc = 1;
            while (!oDone && cyc < TO + 50) begin
                @(negedge clk);
                cyc++;
            end
            chk("wd_cycles", 256'(cyc), 256'(TO + 2));
            chk("wd_done_err", 256'({oDone, oError}), 256'(2'b11));
            chk("wd_fields_dropped", 256'({oG_iv_valid, oG_key_valid, oG_hashkey}), 256'(0));
            @(negedge clk);
            chk("wd_idle", 256'({oBusy, oDone, oError}), 256'(3'b001));
            eng_en = 1'b1;
            run_job(0, 1'b0, 1'b0, 1'b0, "wd_recover");
        end
`else
        chk("no_wd_err", 256'(oError), 256'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gctr_job_sequencer.md
# gctr_job_sequencer

Controller in front of the GCTR block engine. It turns one GCM job (IV, key, key length, block count) into the ordered command sequence the engine needs: hash-key derivation, N counter-mode data blocks, then the E(K,Y0) tag mask. It sits between the packet-level GCM control and the engine. It meters plaintext/ciphertext blocks in and out over valid/ready handshakes, and emits H, C[i] and E(K,Y0) on one tagged output stream for the GHASH and tag logic.

## Interface
Parameters:
- CNT_W, 16, width of block-count field (max 2^CNT_W-1 blocks per job)
- TIMEOUT_CYCLES, 1023, engine watchdog limit (only with GCTR_SEQ_TIMEOUT_EN)

Ports (clock and reset first):
- iClk  in  1  clock
- iRst  in  1  reset, asynchronous, active-high
- iStart  in  1  job start pulse, accepted only when oBusy=0
- iIV  in  96  job IV, latched on accepted iStart
- iKey  in  256  job key, latched on accepted iStart; 128-bit keys occupy [0:127]
- iKeylen  in  1  0=AES-128, 1=AES-256, latched on accepted iStart
- iNumBlocks  in  CNT_W  data blocks in job, latched on accepted iStart
- oBusy  out  1  job in progress
- iBlock  in  128  input data block
- iBlock_valid  in  1  input block valid
- oBlock_ready  out  1  sequencer accepts iBlock this cycle
- oOut  out  128  output word
- oOut_type  out  2  00=H, 01=data result, 10=E(K,Y0)
- oOut_valid  out  1  output word valid
- iOut_ready  in  1  downstream accepts oOut
- oDone  out  1  one-cycle pulse at job end
- oError  out  1  watchdog abort flag
- oG_init, oG_iv(96), oG_iv_valid, oG_key(256), oG_key_valid, oG_keylen, oG_y0, oG_hashkey, oG_block(128), oG_block_valid  out  engine command fields
- iG_result  in  128  engine result
- iG_result_valid  in  1  engine result strobe

## Operation
- States: IDLE, HK_ISSUE, HK_WAIT, FETCH, BLK_ISSUE, BLK_WAIT, Y0_ISSUE, Y0_WAIT, OUT, FIN.
- IDLE: on iStart, latch job fields, clear remaining-count to iNumBlocks, clear oError, go to HK_ISSUE.
- *_ISSUE:
  - Drive oG_init=1 for exactly this one cycle.
  - oG_iv/oG_key/oG_keylen come from the latched job, and oG_iv_valid=oG_key_valid=1.
  - HK: oG_hashkey=1, oG_block_valid=0. BLK: oG_block=captured block, oG_block_valid=1. Y0: oG_y0=1, oG_block_valid=0.
  - Next state is the matching *_WAIT.
- *_WAIT: all command fields except oG_init held stable. On iG_result_valid, capture iG_result into the output register, set oOut_type, and go to OUT.
- OUT: oOut_valid=1. On iOut_ready, go to the next step:
  - after H: FETCH, or Y0_ISSUE if count=0.
  - after data: decrement count, then FETCH if count≠0, else Y0_ISSUE.
  - after Y0: FIN.
- FETCH: oBlock_ready=1. On iBlock_valid, capture iBlock and go to BLK_ISSUE. The engine advances the counter; the sequencer never modifies the IV.
- FIN: oDone=1 for one cycle, then IDLE.
- oBusy=1 in every state except IDLE.
- Command fields are zero in IDLE, FETCH, OUT and FIN; oG_iv_valid and oG_key_valid stay 1 from HK_ISSUE through Y0_WAIT.

## Timing
- Reset: all outputs 0, state IDLE, count 0, and the output register cleared. Reset is asserted asynchronously and released synchronously to iClk.
- Reset mid-job: return to IDLE immediately and drop all engine command fields. No oDone pulse is emitted.
- iStart→oG_init: 1 cycle.
- iG_result_valid→oOut_valid: 1 cycle.
- iBlock accept→oG_init: 1 cycle.
- oOut_valid stays asserted with stable oOut/oOut_type until iOut_ready. Only one output word is in flight, so there is no overlap of engine commands.
- iStart while oBusy=1 is ignored, and job registers are unchanged.
- iG_result_valid outside *_WAIT is ignored.
- iBlock_valid while oBlock_ready=0: the block is not consumed.
- iNumBlocks=0: the sequence is H → E(K,Y0). No block is fetched.
- Count wrap: the count never decrements below 0.

## Configuration
- GCTR_SEQ_TIMEOUT_EN defined:
  - A watchdog counter runs in every *_WAIT state and is cleared on entry.
  - If it reaches TIMEOUT_CYCLES without iG_result_valid: set oError=1 (sticky until the next accepted iStart), drop the engine fields, pulse oDone, and go to IDLE.
- GCTR_SEQ_TIMEOUT_EN undefined: no counter; WAIT states wait indefinitely and oError is tied 0.

## Test plan
- AES-256 encryption job:
  - stimulus: key E3C08A8F06C6E3AD95A70557B23F75483CE33021A9C72B7025666204C69C0B72, IV 12153524C0895E81B2C28465, N=3, blocks 08000F10…1B1C / 1D1E1F20…2B2C / 2D2E2F30…0002, iOut_ready=1.
  - required response: outputs H=286D73994EA0BA3CFD1F52BF06A8ACF2, C1=E2006EB42F5277022D9B19925BC419D7, C2=A592666C925FE2EF718EB4E308EFEAA7, C3=C5273B394118860A5BE2A97F56AB7836, EK0=714D54FDCFCEE37D5729CDDAB383A016, in that order with types 00,01,01,01,10, then one oDone pulse.
- Decryption job: same key/IV, blocks C1..C3 → data outputs equal the three plaintext blocks above; H and EK0 are unchanged.
- N=0: → exactly two outputs (H, EK0) and oBlock_ready never asserted.
- Backpressure/stall: iOut_ready held 0 for 10 cycles on each word, iBlock_valid delayed 5 cycles, iStart pulsed mid-job → oOut stable while stalled, exactly one oG_init per command, results identical to the encryption job.
- Reset and watchdog:
  - iRst asserted in BLK_WAIT → outputs 0 next edge; a new job then completes correctly.
  - With GCTR_SEQ_TIMEOUT_EN and the engine result suppressed → oError=1 and oDone pulse after TIMEOUT_CYCLES, state back to IDLE.
